// File: rtl/fifo_arb_pkg.sv
// Shared types and sizing helpers for the FIFO write-side arbiter.
package fifo_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_e;

   // The counter must hold values 0..max_burst.
   function automatic int burst_cnt_width(input int max_burst);
      return $clog2(max_burst + 1);
   endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: the first set request strictly after
// last_owner, wrapping modulo N_REQ.
module rr_picker #(
   parameter int N_REQ = 4,
   parameter int IDX_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] last_owner,
   output logic [IDX_W-1:0] winner,
   output logic             any_req
);

   // Sum never exceeds 2*N_REQ-1, so one subtraction is enough to wrap.
   function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int off);
      logic [IDX_W:0] sum;
      sum = {1'b0, base} + (IDX_W+1)'(off);
      if (sum >= (IDX_W+1)'(N_REQ)) begin
         sum = sum - (IDX_W+1)'(N_REQ);
      end
      return sum[IDX_W-1:0];
   endfunction

   logic [N_REQ-1:0] rot;
   logic [IDX_W-1:0] offset;

   for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot
      assign rot[gi] = req[wrap_add(last_owner, gi + 1)];
   end

   always_comb begin
      offset = '0;
      for (int j = N_REQ - 1; j >= 0; j--) begin
         if (rot[j]) begin
            offset = IDX_W'(j);
         end
      end
      winner = wrap_add(last_owner, int'(offset) + 1);
   end

   assign any_req = |req;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among N_REQ producers.
// Write strobes are combinational so fifo_full suppresses them in the same cycle.
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int N_REQ     = 4,
   parameter int DW        = 8,
   parameter int MAX_BURST = 4
) (
   input  logic                     wr_clk,
   input  logic                     rst_n,
   input  logic [N_REQ-1:0]         req,
   input  logic [N_REQ*DW-1:0]      req_data,
   output logic [N_REQ-1:0]         gnt,
   input  logic                     fifo_full,
   output logic                     fifo_wr_en,
   output logic [DW-1:0]            fifo_wdata,
   output logic [$clog2(N_REQ)-1:0] owner,
   output logic                     busy
);

   localparam int IDX_W = $clog2(N_REQ);
   localparam int CNT_W = burst_cnt_width(MAX_BURST);

   arb_state_e       state_q, state_d;
   logic [IDX_W-1:0] owner_q, owner_d;
   logic [IDX_W-1:0] last_owner_q, last_owner_d;
   logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
   logic [IDX_W-1:0] winner;
   logic             any_req;
   logic             owner_req;
   logic             accept;
   logic             last_word;

   rr_picker #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_picker (
      .req        (req),
      .last_owner (last_owner_q),
      .winner     (winner),
      .any_req    (any_req)
   );

   assign owner_req = req[owner_q];
   assign busy      = (state_q == GRANT);
   assign accept    = busy & owner_req & ~fifo_full;
   assign last_word = (burst_cnt_q == CNT_W'(MAX_BURST - 1));

   always_ff @(posedge wr_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         owner_q      <= '0;
         last_owner_q <= IDX_W'(N_REQ - 1);
         burst_cnt_q  <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
         burst_cnt_q  <= burst_cnt_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_owner_d = last_owner_q;
      burst_cnt_d  = burst_cnt_q;
      case (state_q)
         IDLE: begin
            if (any_req) begin
               owner_d     = winner;
               burst_cnt_d = '0;
               state_d     = GRANT;
            end
         end
         GRANT: begin
            // A withdrawn request releases even while the FIFO is full.
            if (!owner_req || (accept && last_word)) begin
               state_d      = IDLE;
               last_owner_d = owner_q;
            end else if (accept) begin
               burst_cnt_d = burst_cnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   for (genvar gi = 0; gi < N_REQ; gi++) begin : g_gnt
      assign gnt[gi] = accept && (owner_q == IDX_W'(gi));
   end

   always_comb begin
      fifo_wdata = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (busy && (owner_q == IDX_W'(i))) begin
            fifo_wdata = req_data[i*DW +: DW];
         end
      end
   end

   assign fifo_wr_en = accept;
   assign owner      = owner_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed self-checking bench for fifo_wr_arbiter (N_REQ=4, DW=8, MAX_BURST=4).
// Requester i presents {i, n} where n counts its own accepted words.
module tb_fifo_wr_arbiter;

   localparam int N  = 4;
   localparam int DW = 8;
   localparam int MB = 4;

   logic            wr_clk = 1'b0;
   logic            rst_n  = 1'b1;
   logic [N-1:0]    req    = '0;
   logic [N*DW-1:0] req_data;
   logic [N-1:0]    gnt;
   logic            fifo_full = 1'b0;
   logic            fifo_wr_en;
   logic [DW-1:0]   fifo_wdata;
   logic [1:0]      owner;
   logic            busy;

   int         total    = 0;
   int         bad      = 0;
   int         wr_count = 0;
   logic [7:0] wlog[$];
   logic [3:0] seq_n[N];

   fifo_wr_arbiter #(
      .N_REQ     (N),
      .DW        (DW),
      .MAX_BURST (MB)
   ) dut (
      .wr_clk     (wr_clk),
      .rst_n      (rst_n),
      .req        (req),
      .req_data   (req_data),
      .gnt        (gnt),
      .fifo_full  (fifo_full),
      .fifo_wr_en (fifo_wr_en),
      .fifo_wdata (fifo_wdata),
      .owner      (owner),
      .busy       (busy)
   );

   always #5 wr_clk = ~wr_clk;

   // Producer model: advance a requester's word only after an accepting edge.
   always @(posedge wr_clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N; i++) seq_n[i] <= 4'd0;
      end else begin
         for (int i = 0; i < N; i++) if (gnt[i]) seq_n[i] <= seq_n[i] + 4'd1;
      end
   end

   always_comb begin
      for (int i = 0; i < N; i++) req_data[i*DW +: DW] = {4'(i), seq_n[i]};
   end

   // Mid-cycle monitor: full-flag safety and write log.
   always @(negedge wr_clk) begin
      total++;
      if (fifo_wr_en && fifo_full) begin
         bad++;
         $display("FAIL wr_while_full: wr_en=%0b full=%0b at %0t", fifo_wr_en, fifo_full, $time);
      end
      if (fifo_wr_en) begin
         wr_count++;
         wlog.push_back(fifo_wdata);
      end
   end

   task automatic tick();
      @(posedge wr_clk);
      #1;
   endtask

   task automatic test_reset();
      #1 rst_n = 1'b0;
      #2;
      total++;
      if (busy !== 1'b0 || gnt !== 4'b0 || fifo_wr_en !== 1'b0) begin
         bad++;
         $display("FAIL reset_outputs: busy=%0b gnt=%b wr_en=%0b, want 0 0000 0", busy, gnt, fifo_wr_en);
      end
      total++;
      if (fifo_wdata !== 8'h00 || owner !== 2'd0) begin
         bad++;
         $display("FAIL reset_data_owner: wdata=%h owner=%0d, want 00 0", fifo_wdata, owner);
      end
      total++;
      if (dut.last_owner_q !== 2'd3 || dut.burst_cnt_q !== 3'd0) begin
         bad++;
         $display("FAIL reset_regs: last_owner=%0d burst_cnt=%0d, want 3 0", dut.last_owner_q, dut.burst_cnt_q);
      end
   endtask

   task automatic test_reset_priority();
      int wr_start;
      logic [1:0] eo;
      tick();
      rst_n = 1'b1;
      req   = 4'b1111;
      #1;
      wr_start = wr_count;
      total++;
      if (busy !== 1'b0 || fifo_wr_en !== 1'b0) begin
         bad++;
         $display("FAIL prio_first_idle: busy=%0b wr_en=%0b, want 0 0", busy, fifo_wr_en);
      end
      for (int g = 0; g < 5; g++) begin
         eo = 2'(g % 4);
         for (int k = 0; k < MB; k++) begin
            tick();
            #1;
            total++;
            if (busy !== 1'b1 || owner !== eo || gnt !== (4'b0001 << eo) || fifo_wr_en !== 1'b1) begin
               bad++;
               $display("FAIL prio_burst g%0d w%0d: busy=%0b owner=%0d gnt=%b wr_en=%0b, want 1 %0d %b 1",
                        g, k, busy, owner, gnt, fifo_wr_en, eo, 4'b0001 << eo);
            end
         end
         tick();
         if (g == 4) req = 4'b0000;
         #1;
         total++;
         if (busy !== 1'b0 || fifo_wr_en !== 1'b0) begin
            bad++;
            $display("FAIL prio_gap g%0d: busy=%0b wr_en=%0b, want 0 0", g, busy, fifo_wr_en);
         end
         if (g == 3) begin
            total++;
            if (wr_count - wr_start !== 16) begin
               bad++;
               $display("FAIL prio_throughput: writes=%0d in 20 cycles, want 16", wr_count - wr_start);
            end
         end
      end
   endtask

   task automatic test_rr_skip();
      logic [1:0] exp_own[3] = '{2'd3, 2'd1, 2'd3};
      tick();
      req = 4'b0010;
      #1;
      for (int k = 0; k < MB; k++) begin
         tick();
         #1;
         total++;
         if (owner !== 2'd1 || gnt !== 4'b0010) begin
            bad++;
            $display("FAIL rr_setup w%0d: owner=%0d gnt=%b, want 1 0010", k, owner, gnt);
         end
      end
      tick();
      req = 4'b1010;
      #1;
      total++;
      if (busy !== 1'b0 || dut.last_owner_q !== 2'd1) begin
         bad++;
         $display("FAIL rr_last_owner: busy=%0b last_owner=%0d, want 0 1", busy, dut.last_owner_q);
      end
      for (int g = 0; g < 3; g++) begin
         for (int k = 0; k < MB; k++) begin
            tick();
            #1;
            total++;
            if (owner !== exp_own[g] || gnt !== (4'b0001 << exp_own[g])) begin
               bad++;
               $display("FAIL rr_skip g%0d w%0d: owner=%0d gnt=%b, want %0d %b",
                        g, k, owner, gnt, exp_own[g], 4'b0001 << exp_own[g]);
            end
         end
         tick();
         if (g == 2) req = 4'b0000;
         #1;
      end
   endtask

   task automatic test_backpressure();
      int wr_start;
      tick();
      req = 4'b0100;
      #1;
      tick();
      #1;
      wr_start = wr_count;
      total++;
      if (owner !== 2'd2 || gnt !== 4'b0100 || dut.burst_cnt_q !== 3'd0) begin
         bad++;
         $display("FAIL bp_first: owner=%0d gnt=%b cnt=%0d, want 2 0100 0", owner, gnt, dut.burst_cnt_q);
      end
      for (int c = 0; c < 3; c++) begin
         tick();
         fifo_full = 1'b1;
         #1;
         total++;
         if (fifo_wr_en !== 1'b0 || gnt !== 4'b0 || busy !== 1'b1 || dut.burst_cnt_q !== 3'd1) begin
            bad++;
            $display("FAIL bp_hold c%0d: wr_en=%0b gnt=%b busy=%0b cnt=%0d, want 0 0000 1 1",
                     c, fifo_wr_en, gnt, busy, dut.burst_cnt_q);
         end
      end
      tick();
      fifo_full = 1'b0;
      #1;
      total++;
      if (fifo_wr_en !== 1'b1 || dut.burst_cnt_q !== 3'd1) begin
         bad++;
         $display("FAIL bp_resume: wr_en=%0b cnt=%0d, want 1 1", fifo_wr_en, dut.burst_cnt_q);
      end
      tick();
      #1;
      total++;
      if (fifo_wr_en !== 1'b1 || dut.burst_cnt_q !== 3'd2) begin
         bad++;
         $display("FAIL bp_third: wr_en=%0b cnt=%0d, want 1 2", fifo_wr_en, dut.burst_cnt_q);
      end
      tick();
      fifo_full = 1'b1;
      #1;
      total++;
      if (fifo_wr_en !== 1'b0 || busy !== 1'b1 || dut.burst_cnt_q !== 3'd3) begin
         bad++;
         $display("FAIL bp_full_on_last: wr_en=%0b busy=%0b cnt=%0d, want 0 1 3", fifo_wr_en, busy, dut.burst_cnt_q);
      end
      tick();
      fifo_full = 1'b0;
      #1;
      total++;
      if (fifo_wr_en !== 1'b1 || gnt !== 4'b0100) begin
         bad++;
         $display("FAIL bp_last_word: wr_en=%0b gnt=%b, want 1 0100", fifo_wr_en, gnt);
      end
      tick();
      req = 4'b0000;
      #1;
      total++;
      if (busy !== 1'b0 || dut.last_owner_q !== 2'd2 || wr_count - wr_start !== 4) begin
         bad++;
         $display("FAIL bp_release: busy=%0b last_owner=%0d writes=%0d, want 0 2 4",
                  busy, dut.last_owner_q, wr_count - wr_start);
      end
   endtask

   task automatic test_early_withdraw();
      tick();
      req = 4'b0010;
      #1;
      tick();
      #1;
      total++;
      if (owner !== 2'd1 || gnt !== 4'b0010) begin
         bad++;
         $display("FAIL ew_w1: owner=%0d gnt=%b, want 1 0010", owner, gnt);
      end
      tick();
      req = 4'b0110;
      #1;
      total++;
      if (gnt !== 4'b0010) begin
         bad++;
         $display("FAIL ew_w2: gnt=%b, want 0010", gnt);
      end
      tick();
      req = 4'b0100;
      #1;
      total++;
      if (gnt !== 4'b0000 || fifo_wr_en !== 1'b0 || busy !== 1'b1) begin
         bad++;
         $display("FAIL ew_drop: gnt=%b wr_en=%0b busy=%0b, want 0000 0 1", gnt, fifo_wr_en, busy);
      end
      tick();
      #1;
      total++;
      if (busy !== 1'b0 || dut.last_owner_q !== 2'd1) begin
         bad++;
         $display("FAIL ew_release: busy=%0b last_owner=%0d, want 0 1", busy, dut.last_owner_q);
      end
      tick();
      #1;
      total++;
      if (owner !== 2'd2 || gnt !== 4'b0100) begin
         bad++;
         $display("FAIL ew_next: owner=%0d gnt=%b, want 2 0100", owner, gnt);
      end
      tick();
      req = 4'b0000;
      fifo_full = 1'b1;
      #1;
      total++;
      if (gnt !== 4'b0000 || fifo_wr_en !== 1'b0 || busy !== 1'b1) begin
         bad++;
         $display("FAIL ew_drop_full: gnt=%b wr_en=%0b busy=%0b, want 0000 0 1", gnt, fifo_wr_en, busy);
      end
      tick();
      fifo_full = 1'b0;
      #1;
      total++;
      if (busy !== 1'b0 || dut.last_owner_q !== 2'd2) begin
         bad++;
         $display("FAIL ew_full_release: busy=%0b last_owner=%0d, want 0 2", busy, dut.last_owner_q);
      end
   endtask

   task automatic test_data_integrity();
      logic [7:0] exp_log[12] = '{8'h3C, 8'h3D, 8'h3E, 8'h3F,
                                  8'h08, 8'h09, 8'h0A, 8'h0B,
                                  8'h1E, 8'h1F, 8'h10, 8'h11};
      tick();
      req = 4'b1111;
      wlog.delete();
      #1;
      for (int g = 0; g < 3; g++) begin
         for (int k = 0; k < MB; k++) tick();
         tick();
         if (g == 2) req = 4'b0000;
         #1;
      end
      total++;
      if (wlog.size() !== 12) begin
         bad++;
         $display("FAIL data_count: writes=%0d, want 12", wlog.size());
      end
      for (int i = 0; i < 12; i++) begin
         if (i < wlog.size()) begin
            total++;
            if (wlog[i] !== exp_log[i]) begin
               bad++;
               $display("FAIL data_word %0d: got %h, want %h", i, wlog[i], exp_log[i]);
            end
         end
      end
   endtask

   task automatic test_reset_mid_burst();
      tick();
      req = 4'b1111;
      #1;
      tick();
      #1;
      total++;
      if (owner !== 2'd2 || gnt !== 4'b0100) begin
         bad++;
         $display("FAIL rmb_first: owner=%0d gnt=%b, want 2 0100", owner, gnt);
      end
      tick();
      rst_n = 1'b0;
      #1;
      total++;
      if (fifo_wr_en !== 1'b0 || busy !== 1'b0 || gnt !== 4'b0000) begin
         bad++;
         $display("FAIL rmb_abort: wr_en=%0b busy=%0b gnt=%b, want 0 0 0000", fifo_wr_en, busy, gnt);
      end
      tick();
      rst_n = 1'b1;
      #1;
      total++;
      if (busy !== 1'b0 || dut.last_owner_q !== 2'd3) begin
         bad++;
         $display("FAIL rmb_idle: busy=%0b last_owner=%0d, want 0 3", busy, dut.last_owner_q);
      end
      tick();
      #1;
      total++;
      if (busy !== 1'b1 || owner !== 2'd0 || gnt !== 4'b0001) begin
         bad++;
         $display("FAIL rmb_owner0: busy=%0b owner=%0d gnt=%b, want 1 0 0001", busy, owner, gnt);
      end
      req = 4'b0000;
   endtask

   initial begin
      test_reset();
      test_reset_priority();
      test_rr_skip();
      test_backpressure();
      test_early_withdraw();
      test_data_integrity();
      test_reset_mid_burst();
      tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
